mod_counter_n: RTL and testbench
================================

MOD_COUNTER_N -- requirements
Module: mod_counter_n

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits, 1..32.
REQ-002 Parameter MODULO, default 16: count range 0..MODULO-1, 2 <= MODULO <= 2^WIDTH.
REQ-003 Parameter DIV, default 1: prescaler ratio, one count step per DIV enabled clocks, DIV >= 1.
REQ-004 Parameter SATURATE, default 0: 0 wraps at range ends, 1 holds at range ends.
REQ-005 iClk  in  1  the single clock; all state changes on its rising edge.
REQ-006 iRst_n  in  1  asynchronous active-low reset.
REQ-007 iEn  in  1  count enable; gates the prescaler and the count step.
REQ-008 iUp  in  1  direction: 1 up, 0 down; sampled at each step.
REQ-009 iClr  in  1  synchronous clear.
REQ-010 iLoad  in  1  synchronous load strobe.
REQ-011 iLoadVal  in  WIDTH  load value.
REQ-012 oCounter  out  WIDTH  registered count value.
REQ-013 oCarry  out  1  combinational cascade output: iEn & step & count at terminal value for current direction.
REQ-014 oWrap  out  1  registered one-cycle pulse: previous edge wrapped, or would have wrapped when SATURATE=1.
REQ-015 oTick  out  1  combinational prescaler step strobe.

Function
REQ-016 Priority per edge SHALL be iClr > iLoad > count step > hold.
REQ-017 iClr SHALL set oCounter to 0 and the prescaler to 0. oWrap SHALL be 0 on the next cycle.
REQ-018 iLoad without iClr SHALL set oCounter to iLoadVal and the prescaler to 0. Values >= MODULO SHALL be clamped to MODULO-1.
REQ-019 The prescaler SHALL count 0..DIV-1 while iEn=1 and hold while iEn=0.
REQ-020 oTick SHALL be high when iEn=1 and prescaler = DIV-1. With DIV=1, oTick = iEn.
REQ-021 Step SHALL occur on an edge with oTick=1 and no iClr or iLoad. Latency is 1 clock: the new oCounter is visible after that edge.
REQ-022 Up step: count < MODULO-1 increments by 1. At MODULO-1, count goes to 0 (SATURATE=0) or holds (SATURATE=1).
REQ-023 Down step: count > 0 decrements by 1. At 0, count goes to MODULO-1 (SATURATE=0) or holds (SATURATE=1).
REQ-024 Terminal value SHALL be MODULO-1 for up and 0 for down. oCarry = oTick & (count == terminal).
REQ-025 oWrap SHALL pulse 1 cycle after each step taken at terminal value, in both SATURATE modes.
REQ-026 iUp changing mid-prescale SHALL affect only the next step. No step is lost or duplicated.
REQ-027 iClr or iLoad coinciding with oTick SHALL suppress that step and its oWrap.
REQ-028 All arithmetic SHALL be WIDTH bits, unsigned. No intermediate value may exceed MODULO-1 when stored.
REQ-029 Cascading oCarry of stage k into iEn of stage k+1 (DIV=1) SHALL form a correct multi-digit counter, e.g. MODULO=10 for BCD.

Reset
REQ-030 iRst_n low SHALL immediately force oCounter=0, prescaler=0, oWrap=0, independent of iClk.
REQ-031 Release SHALL be synchronous to iClk. The first step can occur no earlier than the first edge after release.
REQ-032 Reset asserted mid-prescale or mid-load SHALL discard all partial state.

Structure
REQ-033 Shared package cnt_pkg SHALL hold the direction constants CNT_UP=1 and CNT_DOWN=0, the mode constants CNT_WRAP=0 and CNT_SAT=1, and the function clog2 for prescaler sizing.
REQ-034 The prescaler SHALL be sub-module tick_gen with parameter DIV, ports iClk, iRst_n, iEn, iSync_clr, oTick, and counter width clog2(DIV) (min 1).
REQ-035 mod_counter_n SHALL contain the count register, wrap/saturate logic, oCarry and oWrap.

Verification (WIDTH=4, MODULO=10, DIV=1 unless stated)
REQ-036 Reset, then iEn=1, iUp=1 for 12 clocks -> oCounter 1..9,0,1,2; oWrap high only the cycle after 9->0; oCarry high while count=9.
REQ-037 iUp=0 from 0 for 3 clocks -> 9,8,7; one oWrap pulse after 0->9.
REQ-038 SATURATE=1, up from 8 for 3 clocks -> 9,9,9; oWrap pulses after each step at 9; oCounter never 0.
REQ-039 iLoad=1, iLoadVal=13 -> oCounter=9. iLoad and iClr together -> oCounter=0. iLoad on a tick edge -> load value kept, no increment.
REQ-040 DIV=4, iEn=1 for 16 clocks -> exactly 4 steps. Dropping iEn for 3 clocks mid-prescale delays the next step by exactly 3 clocks.
REQ-041 Two stages cascaded via oCarry count 00..99 and wrap to 00. Async iRst_n pulse between edges at count 57 -> both digits read 0 before the next edge.

Source files
------------

// File: rtl/cnt_pkg.sv
// Shared constants and sizing helper for the modulo counter and its prescaler.
package cnt_pkg;

  localparam logic CNT_UP   = 1'b1;
  localparam logic CNT_DOWN = 1'b0;
  localparam logic CNT_WRAP = 1'b0;
  localparam logic CNT_SAT  = 1'b1;

  // Ceiling log2; returns 0 for n <= 1, so callers clamp to a minimum width of 1.
  function automatic int clog2(input longint unsigned n);
    int r;
    r = 0;
    for (int i = 0; i < 64; i++) begin
      if ((64'd1 << i) < n) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: emits one tick per DIV enabled clocks, freezes while disabled.
module tick_gen
  import cnt_pkg::*;
#(
  parameter int unsigned DIV = 1
) (
  input  logic iClk,
  input  logic iRst_n,
  input  logic iEn,
  input  logic iSync_clr,
  output logic oTick
);

  localparam int unsigned     PW   = (clog2(DIV) < 1) ? 1 : clog2(DIV);
  localparam logic [PW-1:0]   LAST = PW'(DIV - 1);

  logic [PW-1:0] presc_q, presc_d;

  always_comb begin
    presc_d = presc_q;
    if (iSync_clr) begin
      presc_d = {PW{1'b0}};
    end else if (iEn) begin
      if (presc_q == LAST) begin
        presc_d = {PW{1'b0}};
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end else begin
      presc_d = presc_q;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      presc_q <= {PW{1'b0}};
    end else begin
      presc_q <= presc_d;
    end
  end

  assign oTick = iEn & (presc_q == LAST);

endmodule

// File: rtl/mod_counter_n.sv
// Up/down modulo-N counter with prescaler, clear/load, wrap or saturate at range ends,
// and a carry output suitable for cascading digits.
module mod_counter_n
  import cnt_pkg::*;
#(
  parameter int unsigned     WIDTH    = 4,
  parameter longint unsigned MODULO   = 16,
  parameter int unsigned     DIV      = 1,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iEn,
  input  logic             iUp,
  input  logic             iClr,
  input  logic             iLoad,
  input  logic [WIDTH-1:0] iLoadVal,
  output logic [WIDTH-1:0] oCounter,
  output logic             oCarry,
  output logic             oWrap,
  output logic             oTick
);

  localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MODULO - 64'd1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             tick_s, term_s;
  logic [WIDTH-1:0] load_val_s;

  // Clear and load both restart the prescaler so the next step is a full period away.
  tick_gen #(.DIV(DIV)) u_tick_gen (
    .iClk      (iClk),
    .iRst_n    (iRst_n),
    .iEn       (iEn),
    .iSync_clr (iClr | iLoad),
    .oTick     (tick_s)
  );

  always_comb begin
    term_s     = (iUp == CNT_UP) ? (cnt_q == MAX_V) : (cnt_q == {WIDTH{1'b0}});
    load_val_s = ({1'b0, iLoadVal} >= MOD_EXT) ? MAX_V : iLoadVal;
  end

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (iClr) begin
      cnt_d = {WIDTH{1'b0}};
    end else if (iLoad) begin
      cnt_d = load_val_s;
    end else if (tick_s) begin
      wrap_d = term_s;
      if (term_s) begin
        if (SATURATE == CNT_SAT) begin
          cnt_d = cnt_q;
        end else begin
          cnt_d = (iUp == CNT_UP) ? {WIDTH{1'b0}} : MAX_V;
        end
      end else if (iUp == CNT_UP) begin
        cnt_d = cnt_q + WIDTH'(1);
      end else begin
        cnt_d = cnt_q - WIDTH'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      cnt_q  <= {WIDTH{1'b0}};
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign oCounter = cnt_q;
  assign oWrap    = wrap_q;
  assign oCarry   = tick_s & term_s;
  assign oTick    = tick_s;

endmodule

// File: tb/tb_mod_counter_n.sv
// Scoreboard bench: wrapping, saturating, prescaled and cascaded counter instances.
module tb_mod_counter_n;

  typedef struct {
    logic [3:0] cnt;
    logic       wrap;
  } exp_t;

  exp_t sb_q[$];
  int   dsb_q[$];
  int   checks = 0;
  int   passed = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b1;
  logic rst_d_n = 1'b1;

  logic a_en = 0, a_up = 1, a_clr = 0, a_load = 0;
  logic [3:0] a_lv = 4'd0;
  logic [3:0] a_cnt;
  logic a_carry, a_wrap, a_tick;

  logic b_en = 0, b_up = 1, b_clr = 0, b_load = 0;
  logic [3:0] b_lv = 4'd0;
  logic [3:0] b_cnt;
  logic b_carry, b_wrap, b_tick;

  logic c_en = 0;
  logic [3:0] c_cnt;
  logic c_carry, c_wrap, c_tick;

  logic d0_en = 0, d_clr = 0;
  logic [3:0] d0_cnt, d1_cnt;
  logic d0_carry, d0_wrap, d0_tick, d1_carry, d1_wrap, d1_tick;

  mod_counter_n #(.WIDTH(4), .MODULO(10), .DIV(1), .SATURATE(1'b0)) u_a (
    .iClk(clk), .iRst_n(rst_n), .iEn(a_en), .iUp(a_up), .iClr(a_clr), .iLoad(a_load),
    .iLoadVal(a_lv), .oCounter(a_cnt), .oCarry(a_carry), .oWrap(a_wrap), .oTick(a_tick));

  mod_counter_n #(.WIDTH(4), .MODULO(10), .DIV(1), .SATURATE(1'b1)) u_b (
    .iClk(clk), .iRst_n(rst_n), .iEn(b_en), .iUp(b_up), .iClr(b_clr), .iLoad(b_load),
    .iLoadVal(b_lv), .oCounter(b_cnt), .oCarry(b_carry), .oWrap(b_wrap), .oTick(b_tick));

  mod_counter_n #(.WIDTH(4), .MODULO(10), .DIV(4), .SATURATE(1'b0)) u_c (
    .iClk(clk), .iRst_n(rst_n), .iEn(c_en), .iUp(1'b1), .iClr(1'b0), .iLoad(1'b0),
    .iLoadVal(4'd0), .oCounter(c_cnt), .oCarry(c_carry), .oWrap(c_wrap), .oTick(c_tick));

  mod_counter_n #(.WIDTH(4), .MODULO(10), .DIV(1), .SATURATE(1'b0)) u_d0 (
    .iClk(clk), .iRst_n(rst_d_n), .iEn(d0_en), .iUp(1'b1), .iClr(d_clr), .iLoad(1'b0),
    .iLoadVal(4'd0), .oCounter(d0_cnt), .oCarry(d0_carry), .oWrap(d0_wrap), .oTick(d0_tick));

  mod_counter_n #(.WIDTH(4), .MODULO(10), .DIV(1), .SATURATE(1'b0)) u_d1 (
    .iClk(clk), .iRst_n(rst_d_n), .iEn(d0_carry), .iUp(1'b1), .iClr(d_clr), .iLoad(1'b0),
    .iLoadVal(4'd0), .oCounter(d1_cnt), .oCarry(d1_carry), .oWrap(d1_wrap), .oTick(d1_tick));

  task automatic edge_wait();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    #2 rst_n = 1'b0; rst_d_n = 1'b0;
    #1;
    checks++; if (a_cnt !== 4'd0 || a_wrap !== 1'b0) $display("FAIL reset_async_a cnt=%0d wrap=%0b want 0/0", a_cnt, a_wrap); else passed++;
    checks++; if (b_cnt !== 4'd0 || c_cnt !== 4'd0) $display("FAIL reset_async_bc b=%0d c=%0d want 0/0", b_cnt, c_cnt); else passed++;
    checks++; if (d0_cnt !== 4'd0 || d1_cnt !== 4'd0) $display("FAIL reset_async_d d0=%0d d1=%0d want 0/0", d0_cnt, d1_cnt); else passed++;
    edge_wait();
    rst_n = 1'b1; rst_d_n = 1'b1;
    edge_wait();
    checks++; if (a_cnt !== 4'd0 || a_tick !== 1'b0) $display("FAIL reset_idle cnt=%0d tick=%0b want 0/0", a_cnt, a_tick); else passed++;
  endtask

  task automatic test_up_wrap();
    exp_t e;
    a_en = 1'b1; a_up = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      checks++; if (a_carry !== ((i % 10) == 9)) $display("FAIL up_carry[%0d] got %0b want %0b", i, a_carry, ((i % 10) == 9)); else passed++;
      sb_q.push_back('{cnt: 4'((i + 1) % 10), wrap: ((i % 10) == 9)});
      edge_wait();
      e = sb_q.pop_front();
      checks++; if (a_cnt !== e.cnt || a_wrap !== e.wrap) $display("FAIL up_step[%0d] cnt=%0d wrap=%0b want %0d/%0b", i, a_cnt, a_wrap, e.cnt, e.wrap); else passed++;
    end
  endtask

  task automatic test_down_wrap();
    exp_t e;
    logic [3:0] exp_c [3];
    exp_c[0] = 4'd9; exp_c[1] = 4'd8; exp_c[2] = 4'd7;
    a_clr = 1'b1;
    sb_q.push_back('{cnt: 4'd0, wrap: 1'b0});
    edge_wait();
    e = sb_q.pop_front();
    checks++; if (a_cnt !== e.cnt || a_wrap !== e.wrap) $display("FAIL down_clr cnt=%0d wrap=%0b want %0d/%0b", a_cnt, a_wrap, e.cnt, e.wrap); else passed++;
    a_clr = 1'b0; a_up = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (a_carry !== (i == 0)) $display("FAIL down_carry[%0d] got %0b want %0b", i, a_carry, (i == 0)); else passed++;
      sb_q.push_back('{cnt: exp_c[i], wrap: (i == 0)});
      edge_wait();
      e = sb_q.pop_front();
      checks++; if (a_cnt !== e.cnt || a_wrap !== e.wrap) $display("FAIL down_step[%0d] cnt=%0d wrap=%0b want %0d/%0b", i, a_cnt, a_wrap, e.cnt, e.wrap); else passed++;
    end
  endtask

  task automatic test_saturate();
    exp_t e;
    for (int dir = 1; dir >= 0; dir--) begin
      b_en = 1'b0; b_load = 1'b1; b_lv = (dir == 1) ? 4'd8 : 4'd1;
      sb_q.push_back('{cnt: b_lv, wrap: 1'b0});
      edge_wait();
      e = sb_q.pop_front();
      checks++; if (b_cnt !== e.cnt) $display("FAIL sat_load[%0d] got %0d want %0d", dir, b_cnt, e.cnt); else passed++;
      b_load = 1'b0; b_en = 1'b1; b_up = (dir == 1);
      for (int i = 0; i < 3; i++) begin
        #1;
        checks++; if (b_carry !== (i != 0)) $display("FAIL sat_carry[%0d/%0d] got %0b want %0b", dir, i, b_carry, (i != 0)); else passed++;
        sb_q.push_back('{cnt: (dir == 1) ? 4'd9 : 4'd0, wrap: (i != 0)});
        edge_wait();
        e = sb_q.pop_front();
        checks++; if (b_cnt !== e.cnt || b_wrap !== e.wrap) $display("FAIL sat_step[%0d/%0d] cnt=%0d wrap=%0b want %0d/%0b", dir, i, b_cnt, b_wrap, e.cnt, e.wrap); else passed++;
      end
    end
    b_en = 1'b0;
  endtask

  task automatic test_load();
    exp_t e;
    // columns: en, up, clr, load, lv, expected count
    int tbl [7][6];
    tbl[0] = '{0, 1, 0, 1, 13, 9};
    tbl[1] = '{0, 1, 1, 1, 5, 0};
    tbl[2] = '{1, 1, 0, 1, 5, 5};
    tbl[3] = '{1, 1, 0, 1, 9, 9};
    tbl[4] = '{1, 1, 0, 1, 9, 9};
    tbl[5] = '{1, 1, 1, 0, 0, 0};
    tbl[6] = '{0, 0, 0, 1, 15, 9};
    for (int i = 0; i < 7; i++) begin
      a_en = tbl[i][0][0]; a_up = tbl[i][1][0]; a_clr = tbl[i][2][0]; a_load = tbl[i][3][0];
      a_lv = 4'(tbl[i][4]);
      sb_q.push_back('{cnt: 4'(tbl[i][5]), wrap: 1'b0});
      edge_wait();
      e = sb_q.pop_front();
      checks++; if (a_cnt !== e.cnt || a_wrap !== e.wrap) $display("FAIL load[%0d] cnt=%0d wrap=%0b want %0d/%0b", i, a_cnt, a_wrap, e.cnt, e.wrap); else passed++;
    end
    a_en = 1'b0; a_clr = 1'b0; a_load = 1'b0;
    edge_wait();
    checks++; if (a_cnt !== 4'd9 || a_wrap !== 1'b0) $display("FAIL load_hold cnt=%0d wrap=%0b want 9/0", a_cnt, a_wrap); else passed++;
  endtask

  task automatic test_random();
    exp_t e;
    int m;
    logic en, up, clr, ld, wr, car;
    logic [3:0] lv;
    m = 0;
    for (int i = 0; i < 60; i++) begin
      en  = 1'($urandom_range(0, 3) != 0);
      up  = 1'($urandom_range(0, 1));
      clr = (i == 0) ? 1'b1 : 1'($urandom_range(0, 15) == 0);
      ld  = 1'($urandom_range(0, 9) == 0);
      lv  = 4'($urandom_range(0, 15));
      a_en = en; a_up = up; a_clr = clr; a_load = ld; a_lv = lv;
      #1;
      car = en & (up ? (m == 9) : (m == 0));
      if (i != 0) begin
        checks++; if (a_carry !== car) $display("FAIL rnd_carry[%0d] got %0b want %0b", i, a_carry, car); else passed++;
      end
      wr = 1'b0;
      if (clr) m = 0;
      else if (ld) m = (lv > 4'd9) ? 9 : int'(lv);
      else if (en) begin
        wr = up ? (m == 9) : (m == 0);
        if (up) m = (m == 9) ? 0 : m + 1;
        else    m = (m == 0) ? 9 : m - 1;
      end
      sb_q.push_back('{cnt: 4'(m), wrap: wr});
      edge_wait();
      e = sb_q.pop_front();
      checks++; if (a_cnt !== e.cnt || a_wrap !== e.wrap) $display("FAIL rnd[%0d] cnt=%0d wrap=%0b want %0d/%0b", i, a_cnt, a_wrap, e.cnt, e.wrap); else passed++;
    end
    a_en = 1'b0; a_clr = 1'b0; a_load = 1'b0;
  endtask

  task automatic test_prescale();
    exp_t e;
    logic en_pat [7];
    en_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    c_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      checks++; if (c_tick !== ((i % 4) == 3)) $display("FAIL div_tick[%0d] got %0b want %0b", i, c_tick, ((i % 4) == 3)); else passed++;
      sb_q.push_back('{cnt: 4'((i + 1) / 4), wrap: 1'b0});
      edge_wait();
      e = sb_q.pop_front();
      checks++; if (c_cnt !== e.cnt) $display("FAIL div_cnt[%0d] got %0d want %0d", i, c_cnt, e.cnt); else passed++;
    end
    for (int i = 0; i < 7; i++) begin
      c_en = en_pat[i];
      #1;
      checks++; if (c_tick !== (i == 6)) $display("FAIL div_gap_tick[%0d] got %0b want %0b", i, c_tick, (i == 6)); else passed++;
      sb_q.push_back('{cnt: (i == 6) ? 4'd5 : 4'd4, wrap: 1'b0});
      edge_wait();
      e = sb_q.pop_front();
      checks++; if (c_cnt !== e.cnt) $display("FAIL div_gap_cnt[%0d] got %0d want %0d", i, c_cnt, e.cnt); else passed++;
    end
    c_en = 1'b0;
  endtask

  task automatic test_cascade();
    int ev;
    d_clr = 1'b1;
    edge_wait();
    d_clr = 1'b0; d0_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      dsb_q.push_back((i + 1) % 100);
      edge_wait();
      ev = dsb_q.pop_front();
      checks++; if (int'(d1_cnt) * 10 + int'(d0_cnt) !== ev) $display("FAIL cascade[%0d] got %0d%0d want %0d", i, d1_cnt, d0_cnt, ev); else passed++;
    end
    for (int i = 0; i < 57; i++) edge_wait();
    checks++; if (d1_cnt !== 4'd5 || d0_cnt !== 4'd7) $display("FAIL cascade_57 got %0d%0d want 57", d1_cnt, d0_cnt); else passed++;
    #2 rst_d_n = 1'b0;
    #1;
    checks++; if (d1_cnt !== 4'd0 || d0_cnt !== 4'd0) $display("FAIL cascade_async_rst got %0d%0d want 00", d1_cnt, d0_cnt); else passed++;
    #1 rst_d_n = 1'b1;
    dsb_q.push_back(1);
    edge_wait();
    ev = dsb_q.pop_front();
    checks++; if (int'(d1_cnt) * 10 + int'(d0_cnt) !== ev) $display("FAIL cascade_after_rst got %0d%0d want %0d", d1_cnt, d0_cnt, ev); else passed++;
    d0_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_saturate();
    test_load();
    test_random();
    test_prescale();
    test_cascade();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
